// File: rtl/ram_fill_check_pkg.sv
// Shared defaults and FSM state encoding for the RAM fill/check engine.
package ram_fill_check_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/ram_fill_check_cmp.sv
// Read-back checker: delays the expected word/address by one cycle to line up
// with the synchronous RAM output, then tracks Pass, first failing address and count.
module ram_fill_check_cmp
  import ram_fill_check_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              issue_i,
  input  logic [DATA_W-1:0] exp_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_dout_i,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [7:0]        fail_count_o
);

  logic              vld_q;
  logic [DATA_W-1:0] exp_q;
  logic [ADDR_W-1:0] addr_q;
  logic              pass_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [7:0]        fail_count_q;
  logic [7:0]        fail_count_d;
  logic              miss;

  assign miss = vld_q && (mem_dout_i != exp_q);
  assign fail_count_d = (fail_count_q == 8'hFF) ? fail_count_q : fail_count_q + 8'd1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      vld_q        <= 1'b0;
      exp_q        <= '0;
      addr_q       <= '0;
      pass_q       <= 1'b0;
      fail_addr_q  <= '0;
      fail_count_q <= '0;
    end else begin
      vld_q  <= issue_i;
      exp_q  <= exp_i;
      addr_q <= addr_i;
      if (clear_i) begin
        pass_q       <= 1'b1;
        fail_addr_q  <= '0;
        fail_count_q <= '0;
      end else if (miss) begin
        // Pass is still high only until the first miscompare of the run
        pass_q       <= 1'b0;
        fail_count_q <= fail_count_d;
        if (pass_q) fail_addr_q <= addr_q;
      end
    end
  end

  assign pass_o       = pass_q;
  assign fail_addr_o  = fail_addr_q;
  assign fail_count_o = fail_count_q;

endmodule

// File: rtl/ram_fill_check.sv
// RAM fill/check: IDLE wait Start | WRITE fill pattern | READ issue reads |
// DRAIN last compare | DONE one-cycle completion pulse.
module ram_fill_check
  import ram_fill_check_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] len_i,
  input  logic [DATA_W-1:0] seed_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic [ADDR_W-1:0] fail_addr_o,
  output logic [7:0]        fail_count_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_din_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  input  logic [DATA_W-1:0] mem_dout_i
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, len_q;
  logic [DATA_W-1:0] seed_q;
  logic [ADDR_W-1:0] hold_addr_q;
  logic [DATA_W-1:0] hold_din_q;
  logic              accept;
  logic              last_idx;
  logic              mem_active;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] cur_din;

  // Len=0 wraps to the full 2^ADDR_W span because last index is len-1 mod 2^ADDR_W
  assign last_idx   = (idx_q == len_q - ADDR_W'(1));
  assign cur_addr   = base_q + idx_q;
  assign cur_din    = seed_q + DATA_W'(idx_q);
  assign mem_active = (state_q == ST_WRITE) || (state_q == ST_READ);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        idx_d = idx_q + ADDR_W'(1);
        if (last_idx) begin
          idx_d   = '0;
          state_d = ST_READ;
        end
      end
      ST_READ: begin
        idx_d = idx_q + ADDR_W'(1);
        if (last_idx) state_d = ST_DRAIN;
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      base_q      <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      hold_addr_q <= '0;
      hold_din_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (accept) begin
        base_q <= base_addr_i;
        len_q  <= len_i;
        seed_q <= seed_i;
      end
      if (mem_active) hold_addr_q <= cur_addr;
      if (state_q == ST_WRITE) hold_din_q <= cur_din;
    end
  end

  assign busy_o     = (state_q != ST_IDLE);
  assign done_o     = (state_q == ST_DONE);
  assign mem_en_o   = mem_active;
  assign mem_we_o   = (state_q == ST_WRITE);
  assign mem_addr_o = mem_active ? cur_addr : hold_addr_q;
  assign mem_din_o  = (state_q == ST_WRITE) ? cur_din : hold_din_q;

  ram_fill_check_cmp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_cmp (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .clear_i     (accept),
    .issue_i     (state_q == ST_READ),
    .exp_i       (cur_din),
    .addr_i      (cur_addr),
    .mem_dout_i  (mem_dout_i),
    .pass_o      (pass_o),
    .fail_addr_o (fail_addr_o),
    .fail_count_o(fail_count_o)
  );

endmodule

// File: doc/ram_fill_check.md
RAM_FILL_CHECK -- requirements
Module: ram_fill_check

Interface
REQ-001 Parameter ADDR_W, default 8, RAM address width.
REQ-002 Parameter DATA_W, default 10, RAM data width.
REQ-003 Clk  in  1  single clock; all logic on rising edge.
REQ-004 Rst  in  1  reset, synchronous, active-high.
REQ-005 Start  in  1  command strobe; sampled only in IDLE.
REQ-006 BaseAddr  in  ADDR_W  first RAM address of run.
REQ-007 Len  in  ADDR_W  word count N; 0 means N=256.
REQ-008 Seed  in  DATA_W  pattern value for first word.
REQ-009 Busy  out  1  high from cycle after Start accepted until Done cycle inclusive.
REQ-010 Done  out  1  one-cycle completion pulse.
REQ-011 Pass  out  1  result of last run, held until next accepted Start.
REQ-012 FailAddr  out  ADDR_W  address of first miscompare of last run.
REQ-013 FailCount  out  8  miscompare count of last run, saturating at 255.
REQ-014 MemAddr  out  ADDR_W  RAM address.
REQ-015 MemDin  out  DATA_W  RAM write data.
REQ-016 MemEn  out  1  RAM enable.
REQ-017 MemWe  out  1  RAM write enable.
REQ-018 MemDout  in  DATA_W  RAM read data, valid one cycle after a read address with MemEn=1, MemWe=0.

Function
REQ-019 States: IDLE, WRITE, READ, DRAIN, DONE; Start in IDLE latches BaseAddr, Len, Seed, clears FailCount/FailAddr, sets Pass=1 provisionally, goes to WRITE.
REQ-020 WRITE: N cycles, cycle i drives MemEn=1, MemWe=1, MemAddr=BaseAddr+i mod 2^ADDR_W, MemDin=Seed+i mod 2^DATA_W; then READ.
REQ-021 READ: N cycles, cycle i drives MemEn=1, MemWe=0, MemAddr=BaseAddr+i mod 2^ADDR_W; then DRAIN.
REQ-022 Compare: in the cycle after each read issue (READ cycles 1..N-1 and DRAIN), MemDout is compared to Seed+i of the address issued one cycle earlier.
REQ-023 Miscompare: Pass=0; FailCount increments unless 255; FailAddr captured only on first miscompare of the run.
REQ-024 DRAIN: MemEn=0, MemWe=0, final compare; then DONE.
REQ-025 DONE: Done=1 for exactly one cycle, then IDLE; Done rises 2N+2 cycles after the Start-sampling edge.
REQ-026 Outside WRITE/READ: MemEn=0, MemWe=0, MemAddr and MemDin hold last value.
REQ-027 Start while not IDLE is ignored; Start in the DONE cycle is ignored.
REQ-028 Address and pattern wrap silently (BaseAddr=250, N=10 touches 250..255, 0..3).

Reset
REQ-029 Rst in any state, including mid-WRITE/READ, forces IDLE on next edge and aborts the run without Done.
REQ-030 Reset values: Busy=0, Done=0, Pass=0, FailAddr=0, FailCount=0, MemAddr=0, MemDin=0, MemEn=0, MemWe=0.

Structure
REQ-031 Shared package holds ADDR_W/DATA_W defaults and the state enumeration.
REQ-032 One sub-module ram_fill_check_cmp: expected-value delay register, comparator, Pass/FailAddr/FailCount tracking.
REQ-033 Bench uses the existing 256x10 synchronous RAM (1-cycle read) as responder, with a fault-injection option forcing bit 0 of one address.

Verification
REQ-034 Base=2, Len=3, Seed=40 -> writes 40,41,42 at 2..4; Done at cycle 8 after Start; Pass=1, FailCount=0.
REQ-035 Base=250, Len=10, Seed=1020 -> addresses wrap to 0..3, data wraps 1020..1023,0..5; Pass=1.
REQ-036 Fault at address 90, Base=88, Len=5 -> Pass=0, FailAddr=90, FailCount=1.
REQ-037 Len=0, Base=0, faults at 10 and 200 -> 256 writes, Done at cycle 514; FailAddr=10, FailCount=2.
REQ-038 Rst asserted in 3rd READ cycle -> next cycle IDLE, MemEn=0, no Done; Start pulses during Busy ignored.
